// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between a requester and dmem_responder
interface dmem_responder_if #(
  parameter int RAM_ADDRESS_WIDTH = 16,
  parameter int Data_Width        = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic [RAM_ADDRESS_WIDTH-1:0] req_addr;
  logic [Data_Width-1:0]        req_wdata;
  logic [1:0]                   req_dataType;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [Data_Width-1:0]        resp_rdata;
  logic                         resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dataType, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dataType, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressed data memory with fixed-latency valid/ready responses
// Optional misalignment checking is enabled by defining DMEM_RESP_MISALIGN_CHECK_EN.
module dmem_responder #(
  parameter int RAM_ADDRESS_WIDTH = 16,
  parameter int Data_Width        = 32,
  parameter int BYTE_WIDTH        = 8,
  parameter int LATENCY           = 2
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int NBYTES = Data_Width / BYTE_WIDTH;
  localparam int DEPTH  = 1 << RAM_ADDRESS_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]                   r_state;
  logic [3:0]                   r_cnt;
  logic                         r_ready;
  logic                         r_resp_valid;
  logic                         r_err;
  logic [Data_Width-1:0]        r_rdata;
  logic                         r_we;
  logic [RAM_ADDRESS_WIDTH-1:0] r_addr;
  logic [Data_Width-1:0]        r_wdata;
  logic [1:0]                   r_dtype;
  logic [BYTE_WIDTH-1:0]        r_mem [DEPTH];

  logic [NBYTES-1:0]            w_lane_en;
  logic [RAM_ADDRESS_WIDTH-1:0] w_lane_addr [NBYTES];
  logic [Data_Width-1:0]        w_load_data;
  logic                         w_misalign;
  logic                         w_access;
  logic                         w_store;

  always_comb begin
    w_lane_en = '0;
    case (r_dtype)
      2'b01:   w_lane_en[0]   = 1'b1;
      2'b10:   w_lane_en[1:0] = 2'b11;
      default: w_lane_en      = '1;
    endcase
  end

  // Lane addresses wrap naturally at the top of the array.
  always_comb begin
    for (int k = 0; k < NBYTES; k++) begin
      w_lane_addr[k] = r_addr + RAM_ADDRESS_WIDTH'(k);
    end
  end

  always_comb begin
    w_load_data = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (w_lane_en[k]) begin
        w_load_data[k*BYTE_WIDTH +: BYTE_WIDTH] = r_mem[w_lane_addr[k]];
      end
    end
  end

`ifdef DMEM_RESP_MISALIGN_CHECK_EN
  always_comb begin
    case (r_dtype)
      2'b01:   w_misalign = 1'b0;
      2'b10:   w_misalign = r_addr[0];
      default: w_misalign = |r_addr[1:0];
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_store  = w_access && r_we && !w_misalign;

  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (w_lane_en[k]) begin
          r_mem[w_lane_addr[k]] <= r_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // req_ready is registered so it stays low in reset and for the cycle of the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_dtype      <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (bus.req_valid && r_ready) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_dtype <= bus.req_dataType;
            r_cnt   <= CNT_LOAD;
            r_ready <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_misalign;
            r_rdata      <= (r_we || w_misalign) ? '0 : w_load_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_ready      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY=2)
module tb_dmem_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DMEM_RESP_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  dmem_responder_if #(.RAM_ADDRESS_WIDTH(16), .Data_Width(32)) bus ();

  dmem_responder #(
    .RAM_ADDRESS_WIDTH(16), .Data_Width(32), .BYTE_WIDTH(8), .LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns the number of clock edges from accept to resp_valid (99 on timeout).
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [1:0] dt, output int lat);
    int n;
    n = 0;
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd; bus.req_dataType = dt;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    lat = 99;
    if (n < 50) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = ~addr;
      bus.req_wdata = ~wd; bus.req_dataType = ~dt;
      n = 0;
      @(negedge clk);
      while (bus.resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (n < 40) lat = n;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic complete(output logic [31:0] rd, output logic er);
    rd = bus.resp_rdata; er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic xact(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [1:0] dt, output int lat, output logic [31:0] rd, output logic er);
    issue(we, addr, wd, dt, lat);
    complete(rd, er);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_dataType = 2'b00; bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.resp_err); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early: got %b want 0", bus.req_ready); end
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready_edge: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_word;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 16'h0010, 32'hDEADBEEF, 2'b00, lat, rd, er);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL st_word_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL st_word_rdata: got %h want 0", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL st_word_err: got %b want 0", er); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL st_word_ready_after: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL st_word_valid_after: got %b want 0", bus.resp_valid); end
    xact(1'b0, 16'h0010, 32'h0, 2'b00, lat, rd, er);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ld_word_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_word: got %h want deadbeef", rd); end
  endtask

  task automatic test_subword;
    int lat; logic [31:0] rd; logic er;
    // Address 0x11 is bits 15:8 of the word at 0x10; only wdata[7:0] may land.
    xact(1'b1, 16'h0011, 32'h1234565A, 2'b01, lat, rd, er);
    xact(1'b0, 16'h0010, 32'h0, 2'b00, lat, rd, er);
    n_cmp++; if (rd !== 32'hDEAD5AEF) begin n_bad++; $display("FAIL ld_after_byte_st: got %h want dead5aef", rd); end
    xact(1'b0, 16'h0012, 32'h0, 2'b10, lat, rd, er);
    n_cmp++; if (rd !== 32'h0000DEAD) begin n_bad++; $display("FAIL ld_half: got %h want 0000dead", rd); end
    xact(1'b0, 16'h0013, 32'h0, 2'b01, lat, rd, er);
    n_cmp++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL ld_byte: got %h want 000000de", rd); end
    xact(1'b0, 16'h0010, 32'h0, 2'b11, lat, rd, er);
    n_cmp++; if (rd !== 32'hDEAD5AEF) begin n_bad++; $display("FAIL ld_type3: got %h want dead5aef", rd); end
    xact(1'b1, 16'h0014, 32'h00000000, 2'b00, lat, rd, er);
    xact(1'b1, 16'h0014, 32'hCCCC9876, 2'b10, lat, rd, er);
    xact(1'b0, 16'h0014, 32'h0, 2'b00, lat, rd, er);
    n_cmp++; if (rd !== 32'h00009876) begin n_bad++; $display("FAIL st_half: got %h want 00009876", rd); end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] rd; logic er;
    issue(1'b0, 16'h0010, 32'h0, 2'b00, lat);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0012; bus.req_dataType = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
      n_cmp++; if (bus.resp_rdata !== 32'hDEAD5AEF) begin n_bad++; $display("FAIL bp_rdata[%0d]: got %h want dead5aef", i, bus.resp_rdata); end
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.req_ready); end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after: got %b want 0", bus.resp_valid); end
    xact(1'b0, 16'h0010, 32'h0, 2'b00, lat, rd, er);
    n_cmp++; if (rd !== 32'hDEAD5AEF) begin n_bad++; $display("FAIL bp_no_extra_st: got %h want dead5aef", rd); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] rd; logic er;
    logic [7:0] exp_b [4];
    logic [15:0] a;
    xact(1'b1, 16'hFFFE, 32'h0000A5A5, 2'b10, lat, rd, er);
    xact(1'b1, 16'h0000, 32'h00005A5A, 2'b10, lat, rd, er);
    xact(1'b1, 16'hFFFE, 32'h11223344, 2'b00, lat, rd, er);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wrap_st_lat: got %0d want 2", lat); end
    n_cmp++; if (er !== MIS) begin n_bad++; $display("FAIL wrap_st_err: got %b want %b", er, MIS); end
    if (MIS) begin
      exp_b[0] = 8'hA5; exp_b[1] = 8'hA5; exp_b[2] = 8'h5A; exp_b[3] = 8'h5A;
    end else begin
      exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    end
    for (int k = 0; k < 4; k++) begin
      a = 16'hFFFE + 16'(k);
      xact(1'b0, a, 32'h0, 2'b01, lat, rd, er);
      n_cmp++; if (rd !== {24'h0, exp_b[k]}) begin n_bad++; $display("FAIL wrap_byte[%h]: got %h want %h", a, rd, {24'h0, exp_b[k]}); end
    end
    xact(1'b0, 16'hFFFF, 32'h0, 2'b10, lat, rd, er);
    n_cmp++; if (rd !== (MIS ? 32'h0 : {16'h0, exp_b[2], exp_b[1]})) begin n_bad++; $display("FAIL wrap_half_ld: got %h", rd); end
    n_cmp++; if (er !== MIS) begin n_bad++; $display("FAIL wrap_half_err: got %b want %b", er, MIS); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 16'h0020, 32'hCAFEF00D, 2'b00, lat, rd, er);
    xact(1'b0, 16'h0020, 32'h0, 2'b00, lat, rd, er);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mid_pre_ld: got %h want cafef00d", rd); end
    bus.req_we = 1'b1; bus.req_addr = 16'h0020; bus.req_wdata = 32'h12345678;
    bus.req_dataType = 2'b00; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rdata: got %h want 0", bus.resp_rdata); end
    n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", bus.resp_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_after: got %b want 1", bus.req_ready); end
    xact(1'b0, 16'h0020, 32'h0, 2'b00, lat, rd, er);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mid_store_dropped: got %h want cafef00d", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
